// File: rtl/onehot_event_fifo.sv
// onehot_event_fifo
//   Turns the encoder's (code, valid) stream into discrete events and queues
//   them in a small show-ahead FIFO for a slower consumer.
//   An event is a rising valid, or a code change while valid stays high, so a
//   held input produces exactly one entry.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   y_in       encoded code from the encoder
//   valid_in   encoder valid flag
//   out_code   code at FIFO head (don't-care while out_valid=0)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head entry this cycle
//   count      stored entries, 0..2**DEPTH_LOG2
//   overflow   sticky: an event was dropped because the FIFO was full
//   clr_ovf    synchronous clear of overflow (a same-cycle drop wins)
module onehot_event_fifo #(
  parameter int DATA_SIZE  = 2,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_SIZE-1:0]  y_in,
  input  logic                  valid_in,
  output logic [DATA_SIZE-1:0]  out_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  CNT_W    = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [DATA_SIZE-1:0]  code_p0;
  logic                  vld_p0;
  logic [DATA_SIZE-1:0]  code_p1;
  logic                  vld_p1;

  logic [DATA_SIZE-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic evt;
  logic pop;
  logic full;
  logic push;
  logic drop;

  // ---- stage p0: sample the combinational encoder output ----
  // ---- stage p1: one-cycle history used for edge/change detection ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_p0 <= '0;
      vld_p0  <= 1'b0;
      code_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      code_p0 <= y_in;
      vld_p0  <= valid_in;
      code_p1 <= code_p0;
      vld_p1  <= vld_p0;
    end
  end

  // ---- event detect and FIFO control ----
  always_comb begin
    // The code is compared only when the previous sample was also valid;
    // a valid drop followed by the same code therefore counts as a new event.
    evt  = vld_p0 & (~vld_p1 | (code_p0 != code_p1));
    pop  = out_valid & out_ready;
    full = (count == FULL_CNT);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = evt & (~full | pop);
    drop = evt & full & ~pop;
  end

  // Storage is deliberately not reset; count alone says what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= code_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---- show-ahead output, no bypass from the write side ----
  assign out_code  = mem[rd_ptr];
  assign out_valid = (count != '0);

endmodule

// File: tb/tb_onehot_event_fifo.sv
module tb_onehot_event_fifo;

  logic       clk;
  logic       rst_n;
  logic [1:0] y_in;
  logic       valid_in;
  logic [1:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  onehot_event_fifo #(.DATA_SIZE(2), .DEPTH_LOG2(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_in),
    .valid_in  (valid_in),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Input history of the last two sampled (valid, code) pairs plus a queue
  // holding the FIFO contents in arrival order.
  logic [1:0] mq [$];
  logic       m_s_v, m_p_v, m_ovf;
  logic [1:0] m_s_c, m_p_c;
  logic       m_ev, m_pop, m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_s_v = 1'b0; m_s_c = 2'b00;
      m_p_v = 1'b0; m_p_c = 2'b00;
      m_ovf = 1'b0;
    end else begin
      m_ev   = m_s_v && (!m_p_v || (m_s_c != m_p_c));
      m_full = (mq.size() == 4);
      m_pop  = (mq.size() != 0) && out_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_ev) begin
        if (!m_full || m_pop) mq.push_back(m_s_c);
        else m_ovf = 1'b1;
      end
      if (!(m_ev && m_full && !m_pop) && clr_ovf) m_ovf = 1'b0;
      m_p_v = m_s_v; m_p_c = m_s_c;
      m_s_v = valid_in; m_s_c = y_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mdl_out_valid", int'(out_valid), int'(mq.size() != 0));
      chk("mdl_count", int'(count), mq.size());
      chk("mdl_overflow", int'(overflow), int'(m_ovf));
      if (mq.size() != 0) chk("mdl_out_code", int'(out_code), int'(mq[0]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic v, input logic [1:0] c, input logic r, input logic cl);
    valid_in = v; y_in = c; out_ready = r; clr_ovf = cl;
    @(negedge clk);
  endtask

  task automatic drain4(input string nm, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
    logic [1:0] e [4];
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_head%0d", nm, i), int'(out_code), int'(e[i]));
      chk($sformatf("%s_cnt%0d", nm, i), int'(count), 4 - i);
      cyc(1'b0, 2'b00, 1'b1, 1'b0);
    end
    chk($sformatf("%s_empty", nm), int'(out_valid), 0);
  endtask

  task automatic fill5;
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; y_in = 2'b00; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;

    // Test 1: asynchronous reset with two entries stored
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t1_count_pre", int'(count), 2);
    valid_in = 1'b1; y_in = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_valid", int'(out_valid), 0);
    chk("t1_async_count", int'(count), 0);
    chk("t1_async_ovf", int'(overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    chk("t1_rel_cnt1", int'(count), 0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    chk("t1_rel_cnt2", int'(count), 1);
    chk("t1_rel_code", int'(out_code), 3);
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    chk("t1_rel_cnt3", int'(count), 1);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t1_drained", int'(count), 0);

    // Test 2: held input yields a single event
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    chk("t2_cnt_e1", int'(count), 0);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    chk("t2_cnt_e2", int'(count), 1);
    chk("t2_code", int'(out_code), 2);
    chk("t2_valid", int'(out_valid), 1);
    repeat (4) cyc(1'b1, 2'b10, 1'b0, 1'b0);
    chk("t2_cnt_end", int'(count), 1);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t2_drained", int'(out_valid), 0);

    // Test 3: event sequence (the invalid cycle carries a junk code)
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 2'b10, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t3_count", int'(count), 4);
    drain4("t3", 2'b11, 2'b01, 2'b01, 2'b00);

    // Test 4: overflow and clear
    fill5();
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("t4_count", int'(count), 4);
    chk("t4_ovf", int'(overflow), 1);
    drain4("t4", 2'b00, 2'b01, 2'b10, 2'b11);
    chk("t4_ovf_held", int'(overflow), 1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("t4_ovf_clr", int'(overflow), 0);

    // Test 5: full FIFO, push and pop in the same cycle
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    fill5();
    chk("t5_full", int'(count), 4);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    chk("t5_count", int'(count), 4);
    chk("t5_ovf", int'(overflow), 0);
    drain4("t5", 2'b01, 2'b10, 2'b11, 2'b00);

    // Test 6: drop collides with clear, then pops on empty
    fill5();
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("t6_ovf", int'(overflow), 1);
    chk("t6_count", int'(count), 4);
    drain4("t6", 2'b00, 2'b01, 2'b10, 2'b11);
    repeat (3) cyc(1'b0, 2'b00, 1'b1, 1'b0);
    chk("t6_underflow_cnt", int'(count), 0);
    chk("t6_underflow_vld", int'(out_valid), 0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/onehot_event_fifo.md
# onehot_event_fifo

Captures encoded events from the 4-to-2 one-hot encoder stage (code + valid flag) and buffers them for a slower consumer. An event is a rising valid, or a code change while valid stays high. Events queue in a small show-ahead FIFO with a valid/ready output handshake. The block sits directly downstream of the encoder, so a held input produces one event rather than one per cycle.

## Interface
- DATA_SIZE, 2, width of the encoded code (matches encoder `y`)
- DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- y_in  input  DATA_SIZE  encoded code from encoder
- valid_in  input  1  encoder flag_valid
- out_code  output  DATA_SIZE  code at FIFO head
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head this cycle
- count  output  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- clr_ovf  input  1  synchronous clear of overflow

## Operation
- One clock; reset is asynchronous and active-low.
- Stage 1 (sample): `s_code`/`s_valid` register `y_in`/`valid_in` every cycle. This stage isolates the combinational encoder output.
- Stage 2 (history): `p_code`/`p_valid` register `s_code`/`s_valid` every cycle.
- Event: `event = s_valid & (~p_valid | (s_code != p_code))`.
  - A valid drop followed by the same code is a new event.
  - `s_code` is ignored while `s_valid=0`.
- Push: on `event`, write `s_code` at `wr_ptr`.
  - Accepted if `count < DEPTH`, or if `count == DEPTH` and a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` sets.
- Pop: `out_valid & out_ready` advances `rd_ptr`.
  - `out_ready` while empty has no effect and never underflows.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. `count` disambiguates full from empty.
- Show-ahead output:
  - `out_code = mem[rd_ptr]`.
  - `out_valid = (count != 0)`.
  - There is no bypass: a push into an empty FIFO becomes visible the next cycle.
- `overflow`:
  - Set on a dropped event.
  - Cleared by `clr_ovf`.
  - A drop in the same cycle as `clr_ovf` wins (stays 1).

## Timing
- Reset (rst_n low, asynchronous): `s_*`, `p_*`, pointers, `count`, `overflow` → 0.
  - Hence `out_valid=0`, `count=0`, `overflow=0`.
  - `out_code` = `mem[0]`; mem contents are not reset, and `out_code` is don't-care while `out_valid=0`.
- Reset deassertion is taken synchronously by the integrator. The first edge after release is a normal cycle.
- Latency: `y_in`/`valid_in` stable before edge N → sampled at N → event evaluated and pushed at N+1 → `out_valid=1` after edge N+1 (empty FIFO). Total: 2 cycles.
- Minimum event spacing is 1 cycle. A code that changes every cycle while valid produces one event per cycle.
- Pop takes effect at the edge where `out_valid & out_ready` is high. The next entry (or `out_valid=0`) is visible after that edge.
- Reset mid-operation discards all stored entries and history. If `valid_in` is held high through reset, it yields exactly one new event 2 cycles after release.

## Test plan
1. **Reset values:** assert rst_n=0 mid-cycle with count=2 → `out_valid`, `count`, `overflow` go 0 immediately, without waiting for a clock edge.
2. **Held input:** `valid_in=1`, `y_in=2'b10` held 6 cycles, `out_ready=0` → after 2 cycles `count=1`, `out_code=2'b10`; `count` stays 1 through the end.
3. **Event sequence:**
   - Stimulus per cycle (valid,code): (1,11)(1,11)(1,01)(0,xx)(1,01)(1,00), with `out_ready=0`.
   - Required: `count=4`.
   - Then `out_ready=1` pops 11, 01, 01, 00 in order, after which `out_valid=0`.
4. **Overflow:**
   - 5 distinct consecutive events (codes 00,01,10,11,00), `out_ready=0` → `count=4`, `overflow=1`.
   - Drain yields 00,01,10,11.
   - `clr_ovf` pulse → `overflow=0`.
5. **Full with simultaneous push/pop:** FIFO full, one new event with `out_ready=1` in the same cycle → `count` stays 4, `overflow` stays 0, new code appears last when drained.
6. **Clear/drop collision:** `clr_ovf=1` in the same cycle as a dropped event → `overflow=1`. Then `out_ready=1` on an empty FIFO for 3 cycles → `count=0`, no underflow.
